// File: rtl/sortmax_datapath.sv
// sortmax_datapath
//   Data-path responder for the sortmax controller. Executes the controller's
//   control lines y1..y20 (ctl[k] = y(k+1)) on a small word array and returns
//   status lines x1..x5 (stat[k] = x(k+1)). Host load/clear/start on one side,
//   a first-word-fall-through result FIFO on the other.
//
//   Ports:
//     clk, rst          clock (rising edge), asynchronous active-high reset
//     ctl[19:0]         control lines from the controller
//     stat[4:0]         status lines, combinational from registers
//     start, clr        host run request / array clear pulses (ignored while busy)
//     load_valid/ready  host word handshake, load_data is the word
//     out_valid/ready   result FIFO handshake, out_data is the FIFO head
//     busy              run in progress
//     ovf               sticky: a result push was dropped on a full FIFO
//     err_rsv           sticky: a reserved control line (y13..y20) was asserted
module sortmax_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned OFIFO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [19:0]      ctl,
  output logic [4:0]       stat,
  input  logic             start,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             ovf,
  output logic             err_rsv
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = (OFIFO > 1) ? $clog2(OFIFO) : 1;
  localparam int unsigned OCW = $clog2(OFIFO + 1);

  localparam logic [AW-1:0]  IMAX  = AW'(DEPTH - 1);
  localparam logic [CW-1:0]  CFULL = CW'(DEPTH);
  localparam logic [PW-1:0]  PMAX  = PW'(OFIFO - 1);
  localparam logic [OCW-1:0] OFULL = OCW'(OFIFO);

  // Array state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [AW-1:0]    i, j, mi;
  logic [WIDTH-1:0] mx, tmp;
  logic             go;

  // Result FIFO state
  logic [WIDTH-1:0] fifo [OFIFO];
  logic [PW-1:0]    wp, rp;
  logic [OCW-1:0]   fcnt;

  // Decoded control lines
  logic y1, y2, y3, y4, y5, y6, y7, y8, y9, y10, y11, y12;
  logic rsv_hit;

  logic load_beat;
  logic fifo_full, fifo_empty;
  logic pop, push_ok;

  always_comb begin
    y1  = ctl[0];
    y2  = ctl[1];
    y3  = ctl[2];
    y4  = ctl[3];
    y5  = ctl[4];
    y6  = ctl[5];
    y7  = ctl[6];
    y8  = ctl[7];
    y9  = ctl[8];
    y10 = ctl[9];
    y11 = ctl[10];
    y12 = ctl[11];
    rsv_hit = |ctl[19:12];
  end

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PMAX) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    load_ready = !busy && (count < CFULL);
    load_beat  = load_valid && load_ready;
    fifo_full  = (fcnt == OFULL);
    fifo_empty = (fcnt == '0);
    out_valid  = !fifo_empty;
    out_data   = fifo_empty ? '0 : fifo[rp];
    pop        = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same edge.
    push_ok    = y12 && (!fifo_full || pop);
    stat       = {go, fifo_full, (count == '0), (mx >= mem[j]), (i == IMAX)};
  end

  // Array, index and host-side registers. Later assignments in this block
  // take precedence, which encodes the collision rules: y2 over y4, y1 over
  // y9/y10, y8 over y7 on the same address, clr over a same-edge load beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      count   <= '0;
      i       <= '0;
      j       <= '0;
      mi      <= '0;
      mx      <= '0;
      tmp     <= '0;
      go      <= 1'b0;
      busy    <= 1'b0;
      err_rsv <= 1'b0;
    end else begin
      if (load_beat) begin
        mem[count[AW-1:0]] <= load_data;
        count              <= count + CW'(1);
      end
      if (clr && !busy) begin
        count <= '0;
      end

      if (start && !busy && (count != '0)) begin
        go <= 1'b1;
      end
      if (y2) begin
        go   <= 1'b0;
        busy <= 1'b1;
      end
      if (y11) begin
        busy <= 1'b0;
      end

      if (y4 && (i != IMAX)) begin
        i <= i + AW'(1);
      end
      if (y2) begin
        i <= '0;
      end

      if (y5 && (j != IMAX)) begin
        j <= j + AW'(1);
      end
      if (y3) begin
        j <= i;
      end

      if (y9) begin
        mx <= '0;
      end
      if (y10) begin
        mi <= i;
      end
      if (y1) begin
        mx <= mem[j];
        mi <= j;
      end

      if (y6) begin
        tmp <= mem[i];
      end
      if (y7) begin
        mem[i] <= mx;
      end
      if (y8) begin
        mem[mi] <= tmp;
      end

      if (rsv_hit) begin
        err_rsv <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < OFIFO; k++) begin
        fifo[k] <= '0;
      end
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo[wp] <= mem[i];
        wp       <= next_ptr(wp);
      end
      if (pop) begin
        rp <= next_ptr(rp);
      end
      case ({push_ok, pop})
        2'b10:   fcnt <= fcnt + OCW'(1);
        2'b01:   fcnt <= fcnt - OCW'(1);
        default: fcnt <= fcnt;
      endcase
      if (y12 && fifo_full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sortmax_datapath.sv
module tb_sortmax_datapath;

  logic        clk;
  logic        rst;
  logic [19:0] ctl;
  logic [4:0]  stat;
  logic        start, clr;
  logic        load_valid, load_ready;
  logic [7:0]  load_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        busy, ovf, err_rsv;

  int errors = 0;
  int checks = 0;
  logic [7:0] expq[$];

  sortmax_datapath #(.WIDTH(8), .DEPTH(8), .OFIFO(4)) dut (
    .clk(clk), .rst(rst), .ctl(ctl), .stat(stat),
    .start(start), .clr(clr),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ovf(ovf), .err_rsv(err_rsv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] y(input int k);
    logic [19:0] one;
    one = 20'd1;
    return one << (k - 1);
  endfunction

  // Monitor: a pop happens at the next rising edge whenever valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(expq.pop_front()));
        end
      end
    end
  end

  task automatic step(input logic [19:0] c);
    @(negedge clk);
    ctl = c;
    @(posedge clk);
    #1;
    ctl = '0;
  endtask

  task automatic push_step(input logic [19:0] c, input logic [7:0] e);
    expq.push_back(e);
    step(c);
  endtask

  task automatic load(input logic [7:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int n = 0; n < 20; n++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(nm, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] vec [8];
    logic [7:0] mxm;
    logic       x2e;
    vec = '{8'd3, 8'd9, 8'd4, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6};

    rst = 1'b0; ctl = '0; start = 1'b0; clr = 1'b0;
    load_valid = 1'b0; load_data = '0; out_ready = 1'b1;

    // Reset asserted mid-cycle, released on a falling edge
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stat", 32'(stat), 32'(5'b00110));
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err_rsv", 32'(err_rsv), 32'd0);

    pulse_start();
    chk("start_empty_x5", 32'(stat[4]), 32'd0);

    // Load and start
    for (int k = 0; k < 8; k++) begin
      load(vec[k]);
      if (k == 0) chk("load_x3_drop", 32'(stat[2]), 32'd0);
    end
    chk("load_full_ready", 32'(load_ready), 32'd0);
    pulse_start();
    chk("start_x5", 32'(stat[4]), 32'd1);
    step(y(2));
    chk("y2_go_clear", 32'(stat[4]), 32'd0);
    chk("y2_busy", 32'(busy), 32'd1);
    pulse_clr();
    chk("clr_busy_ignored", 32'(stat[2]), 32'd0);

    // Max search
    step(y(9) | y(3));
    mxm = 8'd0;
    for (int k = 0; k < 8; k++) begin
      x2e = (mxm >= vec[k]);
      chk($sformatf("x2_j%0d", k), 32'(stat[1]), 32'(x2e));
      if (!x2e) begin
        step(y(1) | y(5));
        mxm = vec[k];
      end else begin
        step(y(5));
      end
    end
    chk("final_mx", 32'(dut.mx), 32'd9);
    chk("final_mi", 32'(dut.mi), 32'd1);
    step(y(4));
    push_step(y(12), 8'd9);

    // Swap collision at i = mi = 2
    step(y(4));
    step(y(10));
    step(y(6));
    step(y(6) | y(7) | y(8));
    chk("swap_tmp", 32'(dut.tmp), 32'd4);
    push_step(y(12), 8'd4);

    // Index saturation and x1
    repeat (4) step(y(4));
    chk("x1_i6", 32'(stat[0]), 32'd0);
    step(y(4));
    chk("x1_i7", 32'(stat[0]), 32'd1);
    step(y(4));
    chk("x1_sat", 32'(stat[0]), 32'd1);
    push_step(y(12), 8'd6);
    step(y(2) | y(4));
    chk("y2_over_y4", 32'(stat[0]), 32'd0);
    wait_drain("drain1");

    // FIFO boundaries
    out_ready = 1'b0;
    push_step(y(12) | y(4), 8'd3);
    push_step(y(12) | y(4), 8'd9);
    push_step(y(12) | y(4), 8'd4);
    push_step(y(12) | y(4), 8'd7);
    chk("fifo_full_x4", 32'(stat[3]), 32'd1);
    chk("fifo_head", 32'(out_data), 32'd3);
    out_ready = 1'b1;
    push_step(y(12) | y(4), 8'd1);
    out_ready = 1'b0;
    chk("pushpop_no_ovf", 32'(ovf), 32'd0);
    chk("pushpop_full", 32'(stat[3]), 32'd1);
    step(y(12));
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_still_full", 32'(stat[3]), 32'd1);
    out_ready = 1'b1;
    wait_drain("drain2");
    chk("drained_valid", 32'(out_valid), 32'd0);

    // End of run
    step(y(11));
    chk("y11_busy", 32'(busy), 32'd0);
    chk("y11_count_full", 32'(load_ready), 32'd0);
    pulse_clr();
    chk("clr_x3", 32'(stat[2]), 32'd1);
    chk("clr_load_ready", 32'(load_ready), 32'd1);

    // Reserved line
    step(y(18));
    chk("rsv_err", 32'(err_rsv), 32'd1);
    chk("rsv_stat", 32'(stat), 32'(5'b00110));
    chk("rsv_busy", 32'(busy), 32'd0);
    chk("rsv_ovf", 32'(ovf), 32'd1);
    step('0);
    chk("rsv_sticky", 32'(err_rsv), 32'd1);

    // Busy gating with a partially filled array
    load(8'd5);
    pulse_start();
    chk("start2_x5", 32'(stat[4]), 32'd1);
    step(y(2));
    load(8'd77);
    chk("busy_load_ready", 32'(load_ready), 32'd0);
    chk("busy_count", 32'(dut.count), 32'd1);
    pulse_clr();
    chk("busy_clr_x3", 32'(stat[2]), 32'd0);
    step(y(4));
    push_step(y(12), 8'd9);
    wait_drain("drain3");
    step(y(11));
    chk("y11_load_ready", 32'(load_ready), 32'd1);

    // Reset mid-run
    step(y(2));
    chk("run_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stat", 32'(stat), 32'(5'b00110));
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_err", 32'(err_rsv), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_load_ready", 32'(load_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
